// File: rtl/mac_accumulator.sv
// mac_accumulator
//   Accumulate stage of the MAC, sitting directly behind the 5x5 sequential
//   multiplier. Each time the multiplier raises its result flag, the 10-bit
//   product is added into a wider accumulator. After NUM_TERMS products the
//   run completes. The block reports completion, the term count and a
//   sticky overflow flag.
//
// Parameters
//   ACC_WIDTH  accumulator width in bits (10..32)
//   NUM_TERMS  products summed per run (1..255)
//
// Optional build macro
//   MAC_ACCUMULATOR_SATURATION_EN
//     When defined, a carry-out clamps the accumulator to all-ones for the
//     rest of the run. When undefined, the accumulator wraps modulo
//     2^ACC_WIDTH. overflow_o is set in both builds.
//
// Ports
//   acc_clk_i        clock, rising edge
//   acc_nreset_i     asynchronous active-low reset
//   product_i        [9:0] unsigned product from the multiplier
//   product_valid_i  multiplier result flag (level, may be held)
//   start_i          synchronous pulse: clear and begin a new run
//   acc_result_o     [ACC_WIDTH-1:0] accumulated sum
//   term_count_o     [7:0] products accepted in the current run
//   busy_o           high while accumulating (ACCUM)
//   done_o           high once the run is complete (DONE)
//   overflow_o       sticky: a sum exceeded 2^ACC_WIDTH-1 during this run
//
// FSM state is observable on busy_o / done_o (IDLE = both low).
//
// Handshake: product_valid_i is a level flag with no ready/back-pressure.
// A product is taken on the first rising edge where the flag is high after
// having been low. Holding the flag high does not re-accept the product.
// The history of the flag is kept every cycle in every state. A start_i in
// the same cycle as an accept discards the product.
module mac_accumulator #(
  parameter int ACC_WIDTH = 16,
  parameter int NUM_TERMS = 4
) (
  input  logic                 acc_clk_i,
  input  logic                 acc_nreset_i,
  input  logic [9:0]           product_i,
  input  logic                 product_valid_i,
  input  logic                 start_i,
  output logic [ACC_WIDTH-1:0] acc_result_o,
  output logic [7:0]           term_count_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 overflow_o
);

  localparam logic [7:0] LAST_TERM = 8'(NUM_TERMS);
  localparam int         PAD       = ACC_WIDTH + 1 - 10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [7:0]           count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 valid_q;

  logic                 accept;
  logic [ACC_WIDTH:0]   sum;
  logic                 carry;
  logic [ACC_WIDTH-1:0] add_result;
  logic [7:0]           count_inc;

  // Rising-edge detect on the multiplier result flag.
  assign accept    = product_valid_i & ~valid_q;

  // One bit wider than the accumulator so the carry-out is explicit.
  assign sum       = {1'b0, acc_q} + {{PAD{1'b0}}, product_i};
  assign carry     = sum[ACC_WIDTH];
  assign count_inc = count_q + 8'd1;

`ifdef MAC_ACCUMULATOR_SATURATION_EN
  // Once clamped, any later non-zero product carries again and adding
  // zero leaves all-ones, so the value stays pinned for the run.
  assign add_result = carry ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
`else
  assign add_result = sum[ACC_WIDTH-1:0];
`endif

  always_ff @(posedge acc_clk_i or negedge acc_nreset_i) begin
    if (!acc_nreset_i) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      valid_q <= product_valid_i;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (start_i) begin
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end else if (accept) begin
          acc_d   = add_result;
          count_d = count_inc;
          ovf_d   = ovf_q | carry;
          if (count_inc == LAST_TERM) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (start_i) begin
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = S_ACCUM;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign acc_result_o = acc_q;
  assign term_count_o = count_q;
  assign overflow_o   = ovf_q;
  assign busy_o       = (state_q == S_ACCUM);
  assign done_o       = (state_q == S_DONE);

endmodule

// File: tb/tb_mac_accumulator.sv
// Self-checking bench for mac_accumulator.
// Two instances: dut_a (ACC_WIDTH=16, NUM_TERMS=4) and dut_b (ACC_WIDTH=12,
// NUM_TERMS=5). A behavioural model tracks each instance, and every cycle
// the compare loop checks all outputs against it. Directed steps add
// hand-computed literal expectations.
module tb_mac_accumulator;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [9:0]  prod_a = '0, prod_b = '0;
  logic        valid_a = 1'b0, valid_b = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [15:0] acc_a;
  logic [11:0] acc_b;
  logic [7:0]  cnt_a, cnt_b;
  logic        busy_a, busy_b, done_a, done_b, ovf_a, ovf_b;

  mac_accumulator #(.ACC_WIDTH(16), .NUM_TERMS(4)) dut_a (
    .acc_clk_i(clk), .acc_nreset_i(rst_n), .product_i(prod_a),
    .product_valid_i(valid_a), .start_i(start_a), .acc_result_o(acc_a),
    .term_count_o(cnt_a), .busy_o(busy_a), .done_o(done_a), .overflow_o(ovf_a)
  );

  mac_accumulator #(.ACC_WIDTH(12), .NUM_TERMS(5)) dut_b (
    .acc_clk_i(clk), .acc_nreset_i(rst_n), .product_i(prod_b),
    .product_valid_i(valid_b), .start_i(start_b), .acc_result_o(acc_b),
    .term_count_o(cnt_b), .busy_o(busy_b), .done_o(done_b), .overflow_o(ovf_b)
  );

  // ---------------- behavioural model ----------------
  // phase: 0 = idle, 1 = accumulating, 2 = complete
  typedef struct {
    longint acc;
    int     count;
    int     phase;
    bit     ovf;
    bit     prev;
  } model_t;

  model_t ma, mb;

  function automatic model_t model_reset();
    model_t r;
    r.acc = 0; r.count = 0; r.phase = 0; r.ovf = 1'b0; r.prev = 1'b0;
    return r;
  endfunction

  function automatic model_t model_step(model_t m, logic st, logic v, int p,
                                        int w, int n);
    model_t r = m;
    longint limit = longint'(1) << w;
    longint raw;
    r.prev = v;
    if (st) begin
      r.acc = 0; r.count = 0; r.ovf = 1'b0; r.phase = 1;
    end else if (v && !m.prev && m.phase == 1) begin
      raw = m.acc + longint'(p);
      if (raw >= limit) begin
        r.ovf = 1'b1;
`ifdef MAC_ACCUMULATOR_SATURATION_EN
        r.acc = limit - 1;
`else
        r.acc = raw - limit;
`endif
      end else begin
        r.acc = raw;
      end
      r.count = m.count + 1;
      if (r.count == n) r.phase = 2;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= model_reset();
      mb <= model_reset();
    end else begin
      ma <= model_step(ma, start_a, valid_a, int'(prod_a), 16, 4);
      mb <= model_step(mb, start_b, valid_b, int'(prod_b), 12, 5);
    end
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Literal expectations are queued as acc, count, busy, done, ovf.
  task automatic lit(input string tag, input int sel, input longint e_acc,
                     input int e_cnt, input bit e_busy, input bit e_done,
                     input bit e_ovf);
    exp_q.push_back(64'(e_acc));
    exp_q.push_back(64'(e_cnt));
    exp_q.push_back(64'(e_busy));
    exp_q.push_back(64'(e_done));
    exp_q.push_back(64'(e_ovf));
    if (sel == 0) begin
      check({tag, "_acc"},  64'(acc_a),  exp_q.pop_front());
      check({tag, "_cnt"},  64'(cnt_a),  exp_q.pop_front());
      check({tag, "_busy"}, 64'(busy_a), exp_q.pop_front());
      check({tag, "_done"}, 64'(done_a), exp_q.pop_front());
      check({tag, "_ovf"},  64'(ovf_a),  exp_q.pop_front());
    end else begin
      check({tag, "_acc"},  64'(acc_b),  exp_q.pop_front());
      check({tag, "_cnt"},  64'(cnt_b),  exp_q.pop_front());
      check({tag, "_busy"}, 64'(busy_b), exp_q.pop_front());
      check({tag, "_done"}, 64'(done_b), exp_q.pop_front());
      check({tag, "_ovf"},  64'(ovf_b),  exp_q.pop_front());
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      check("m_a_acc",  64'(acc_a),  64'(ma.acc));
      check("m_a_cnt",  64'(cnt_a),  64'(ma.count));
      check("m_a_busy", 64'(busy_a), 64'(ma.phase == 1));
      check("m_a_done", 64'(done_a), 64'(ma.phase == 2));
      check("m_a_ovf",  64'(ovf_a),  64'(ma.ovf));
      check("m_b_acc",  64'(acc_b),  64'(mb.acc));
      check("m_b_cnt",  64'(cnt_b),  64'(mb.count));
      check("m_b_busy", 64'(busy_b), 64'(mb.phase == 1));
      check("m_b_done", 64'(done_b), 64'(mb.phase == 2));
      check("m_b_ovf",  64'(ovf_b),  64'(mb.ovf));
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge, never on it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int sel);
    if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
    cyc();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Raise valid for 'hold' cycles, then drop it for one cycle.
  task automatic pulse(input int sel, input int prod, input int hold);
    if (sel == 0) begin prod_a = 10'(prod); valid_a = 1'b1; end
    else          begin prod_b = 10'(prod); valid_b = 1'b1; end
    repeat (hold) cyc();
    valid_a = 1'b0;
    valid_b = 1'b0;
    cyc();
  endtask

  // ---------------- directed sequence ----------------
`ifdef MAC_ACCUMULATOR_SATURATION_EN
  localparam longint OVF_ACC = 4095;
`else
  localparam longint OVF_ACC = 709;
`endif

  initial begin
    fork
      compare_loop();
    join_none

    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    lit("reset_a", 0, 0, 0, 0, 0, 0);
    lit("reset_b", 1, 0, 0, 0, 0, 0);

    // Valid pulses in IDLE are ignored.
    pulse(0, 77, 1);
    lit("idle_ign", 0, 0, 0, 0, 0, 0);

    // Basic run: 4 x 961.
    do_start(0);
    lit("start", 0, 0, 0, 1, 0, 0);
    pulse(0, 961, 1); lit("basic1", 0, 961,  1, 1, 0, 0);
    pulse(0, 961, 1); lit("basic2", 0, 1922, 2, 1, 0, 0);
    pulse(0, 961, 1); lit("basic3", 0, 2883, 3, 1, 0, 0);
    pulse(0, 961, 1); lit("basic4", 0, 3844, 4, 0, 1, 0);

    // Valid pulses in DONE are ignored.
    pulse(0, 77, 1);
    lit("done_ign", 0, 3844, 4, 0, 1, 0);

    // Held valid is counted once.
    do_start(0);
    pulse(0, 100, 3);
    pulse(0, 25, 1);
    lit("held", 0, 125, 2, 1, 0, 0);

    // Start collides with an accept: start wins.
    do_start(0);
    pulse(0, 200, 1);
    lit("pre_coll", 0, 200, 1, 1, 0, 0);
    prod_a  = 10'd50;
    valid_a = 1'b1;
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    lit("coll", 0, 0, 0, 1, 0, 0);
    cyc();
    lit("coll_hold", 0, 0, 0, 1, 0, 0);
    valid_a = 1'b0;
    cyc();

    // Overflow run on the 12-bit instance: 5 x 961 = 4805.
    do_start(1);
    repeat (5) pulse(1, 961, 1);
    lit("ovf", 1, OVF_ACC, 5, 0, 1, 1);
    do_start(1);
    lit("ovf_clr", 1, 0, 0, 1, 0, 0);

    // Reset mid-run, between clock edges.
    do_start(0);
    pulse(0, 100, 1);
    pulse(0, 200, 1);
    lit("pre_rst", 0, 300, 2, 1, 0, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    lit("mid_rst_a", 0, 0, 0, 0, 0, 0);
    lit("mid_rst_b", 1, 0, 0, 0, 0, 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    pulse(0, 77, 1);
    lit("post_rst_ign", 0, 0, 0, 0, 0, 0);
    do_start(0);
    pulse(0, 5, 1);
    lit("post_rst_run", 0, 5, 1, 1, 0, 0);

    repeat (2) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
- Accumulate stage of the MAC, directly downstream of the 5x5 sequential multiplier.
- Consumes the 10-bit product each time the multiplier flags a final result, and sums a fixed number of products into a wider accumulator.
- Reports completion, term count and overflow to the controlling logic.
- Built from flip-flop registers and the existing ripple adders, matching the rest of the MAC datapath.

Parameters:
- ACC_WIDTH, 16, accumulator width in bits; legal range 10..32.
- NUM_TERMS, 4, number of products summed per accumulation run; legal range 1..255.

Ports:
- acc_clk_i  input  1  clock; all state updates on the rising edge.
- acc_nreset_i  input  1  reset, asynchronous, active-low.
- product_i  input  10  unsigned product, driven from the multiplier result output.
- product_valid_i  input  1  driven from the multiplier is-result flag; may stay high for more than one cycle.
- start_i  input  1  synchronous pulse: clear the accumulator and begin a new run.
- acc_result_o  output  ACC_WIDTH  current accumulated sum.
- term_count_o  output  8  number of products accepted in the current run.
- busy_o  output  1  high in ACCUM.
- done_o  output  1  high in DONE.
- overflow_o  output  1  sticky flag: a sum exceeded 2^ACC_WIDTH-1 during the current run.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is asynchronous and active-low on acc_nreset_i.
  - While reset is low: state=IDLE, acc_result_o=0, term_count_o=0, overflow_o=0, busy_o=0, done_o=0, valid-history register=0.
  - Reset asserted mid-run aborts the run immediately. No partial state survives.
- Product acceptance:
  - Edge detect: an accept event occurs at a rising clk edge when product_valid_i=1 and the registered previous product_valid_i=0.
  - A product held valid for several cycles is counted exactly once.
  - The valid-history register updates every cycle in every state.
- State machine, states IDLE / ACCUM / DONE:
  - IDLE: accept events ignored. start_i=1 -> acc=0, count=0, overflow=0, go to ACCUM.
  - ACCUM, accept event:
    - acc <= acc + zero-extended product_i.
    - count <= count+1.
    - If count+1 == NUM_TERMS, go to DONE.
  - ACCUM, start_i=1: restart the run (clear acc, count and overflow; stay in ACCUM).
  - DONE: outputs held. Accept events ignored. start_i=1 -> clear and go to ACCUM.
- Simultaneous events:
  - start_i and an accept event in the same cycle: start wins and the product is discarded.
  - The edge-detect history still records the valid, so the same product is not accepted next cycle.
- Latency: one cycle. The sum is visible on acc_result_o after the clock edge on which the accept event was detected.
- Arithmetic:
  - Unsigned.
  - The adder is ACC_WIDTH+1 bits wide. Its carry-out sets overflow_o (sticky until start_i or reset).
  - The default (wrap) behaviour is modulo 2^ACC_WIDTH.
- Outputs are registered or decoded from state only. No combinational path from product_i to any output.

Optional Feature:
- Macro: MAC_ACCUMULATOR_SATURATION_EN.
- Defined:
  - On carry-out, acc is clamped to all-ones and overflow_o is set.
  - Once saturated, acc stays all-ones for the rest of the run.
  - count still increments and DONE is still reached normally.
- Undefined: acc wraps modulo 2^ACC_WIDTH; overflow_o is still set.
- Interface is identical in both builds.

Test Plan:
- Basic run (ACC_WIDTH=16, NUM_TERMS=4): reset, start, then 4 single-cycle valids with product 961 (31*31).
  - After each accept: acc_result_o = 961, 1922, 2883, 3844.
  - term_count_o = 1..4.
  - done_o=1 and busy_o=0 after the 4th accept; overflow_o=0.
- Held valid: product 100 with valid held high for 3 cycles, then low, then one more pulse of 25 -> acc=125, term_count_o=2.
- Overflow (ACC_WIDTH=12, NUM_TERMS=5): 5 products of 961 (raw sum 4805).
  - Without the macro: acc=709, overflow_o=1.
  - With MAC_ACCUMULATOR_SATURATION_EN: acc=4095, overflow_o=1.
  - done_o=1 in both builds.
- Start collision: in ACCUM with acc=200, count=1, assert start_i on the same edge as a valid rising edge with product 50.
  - Required: acc=0, count=0, overflow=0, still ACCUM.
  - No accept on the following cycle while valid stays high.
- Reset mid-run: after 2 accepts (acc=300), pull acc_nreset_i low between clock edges.
  - All outputs go to 0 immediately, state=IDLE.
  - Valids after release are ignored until start_i.
- Ignored in IDLE/DONE: valid pulses with product 77 while in IDLE, and while in DONE -> acc_result_o and term_count_o unchanged.
